// File: rtl/tl_arb2.sv
`default_nettype none
// tl_arb2: two-master A/D channel arbiter, one outstanding transaction, grant held A through D.
// Build option ARB_FIXED_PRIO_EN selects fixed priority (master 0 wins ties) instead of round-robin.
module tl_arb2 #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_a_valid,
   output logic          m0_a_ready,
   input  logic [3:0]    m0_a_opcode,
   input  logic [3:0]    m0_a_mask,
   input  logic [AW-1:0] m0_a_address,
   input  logic [DW-1:0] m0_a_data,
   output logic          m0_d_valid,
   input  logic          m0_d_ready,
   output logic [3:0]    m0_d_opcode,
   output logic [DW-1:0] m0_d_data,
   input  logic          m1_a_valid,
   output logic          m1_a_ready,
   input  logic [3:0]    m1_a_opcode,
   input  logic [3:0]    m1_a_mask,
   input  logic [AW-1:0] m1_a_address,
   input  logic [DW-1:0] m1_a_data,
   output logic          m1_d_valid,
   input  logic          m1_d_ready,
   output logic [3:0]    m1_d_opcode,
   output logic [DW-1:0] m1_d_data,
   output logic          a_valid,
   output logic [3:0]    a_opcode,
   output logic [3:0]    a_mask,
   output logic [AW-1:0] a_address,
   output logic [DW-1:0] a_data,
   input  logic          a_ready,
   input  logic          d_valid,
   input  logic [3:0]    d_opcode,
   input  logic [DW-1:0] d_data,
   output logic          d_ready,
   output logic [1:0]    gnt,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, A_PH = 2'd1, D_PH = 2'd2} state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   own_a_valid, own_d_ready, win, d_done;

   assign own_a_valid = owner_q ? m1_a_valid : m0_a_valid;
   assign own_d_ready = owner_q ? m1_d_ready : m0_d_ready;
   assign d_done      = (state_q == D_PH) && d_valid && own_d_ready;

`ifdef ARB_FIXED_PRIO_EN
   assign win = ~m0_a_valid;
`else
   logic last_q, last_d;

   // master 0 wins the first tie after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end

   assign last_d = d_done ? owner_q : last_q;
   assign win    = (m0_a_valid && m1_a_valid) ? ~last_q : m1_a_valid;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      a_valid     = 1'b0;
      a_opcode    = '0;
      a_mask      = '0;
      a_address   = '0;
      a_data      = '0;
      d_ready     = 1'b0;
      m0_a_ready  = 1'b0;
      m1_a_ready  = 1'b0;
      m0_d_valid  = 1'b0;
      m1_d_valid  = 1'b0;
      m0_d_opcode = '0;
      m1_d_opcode = '0;
      m0_d_data   = '0;
      m1_d_data   = '0;
      gnt         = 2'b00;
      busy        = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_a_valid || m1_a_valid) begin
               owner_d = win;
               state_d = A_PH;
            end
         end
         A_PH: begin
            busy = 1'b1;
            gnt  = owner_q ? 2'b10 : 2'b01;
            if (own_a_valid) begin
               a_valid   = 1'b1;
               a_opcode  = owner_q ? m1_a_opcode  : m0_a_opcode;
               a_mask    = owner_q ? m1_a_mask    : m0_a_mask;
               a_address = owner_q ? m1_a_address : m0_a_address;
               a_data    = owner_q ? m1_a_data    : m0_a_data;
            end
            if (owner_q) m1_a_ready = a_ready;
            else         m0_a_ready = a_ready;
            // a request withdrawn before acceptance is dropped without touching the pointer
            if (!own_a_valid)  state_d = IDLE;
            else if (a_ready)  state_d = D_PH;
         end
         D_PH: begin
            busy    = 1'b1;
            gnt     = owner_q ? 2'b10 : 2'b01;
            d_ready = own_d_ready;
            if (owner_q) begin
               m1_d_valid  = d_valid;
               m1_d_opcode = d_opcode;
               m1_d_data   = d_data;
            end else begin
               m0_d_valid  = d_valid;
               m0_d_opcode = d_opcode;
               m0_d_data   = d_data;
            end
            if (d_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_tl_arb2.sv
`default_nettype none
// tb_tl_arb2: directed vector table, corner-case sequences and randomized traffic against a transaction model.
module tb_tl_arb2;

`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic             clk, rst_n;
   logic [1:0]       m_av, m_dr;
   logic [1:0][3:0]  m_op, m_mask, m_addr;
   logic [1:0][31:0] m_ad;
   wire  [1:0]       m_ar, m_dv;
   wire  [1:0][3:0]  m_dop;
   wire  [1:0][31:0] m_dd;
   wire              a_valid, d_ready, busy;
   wire  [3:0]       a_opcode, a_mask, a_address;
   wire  [31:0]      a_data;
   wire  [1:0]       gnt;
   logic             a_ready, d_valid;
   logic [3:0]       d_opcode;
   logic [31:0]      d_data;

   int n_vec = 0;
   int n_err = 0;
   int m1_hs = 0;

   tl_arb2 #(.DW(32), .AW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_a_valid(m_av[0]), .m0_a_ready(m_ar[0]), .m0_a_opcode(m_op[0]), .m0_a_mask(m_mask[0]),
      .m0_a_address(m_addr[0]), .m0_a_data(m_ad[0]), .m0_d_valid(m_dv[0]), .m0_d_ready(m_dr[0]),
      .m0_d_opcode(m_dop[0]), .m0_d_data(m_dd[0]),
      .m1_a_valid(m_av[1]), .m1_a_ready(m_ar[1]), .m1_a_opcode(m_op[1]), .m1_a_mask(m_mask[1]),
      .m1_a_address(m_addr[1]), .m1_a_data(m_ad[1]), .m1_d_valid(m_dv[1]), .m1_d_ready(m_dr[1]),
      .m1_d_opcode(m_dop[1]), .m1_d_data(m_dd[1]),
      .a_valid(a_valid), .a_opcode(a_opcode), .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
      .a_ready(a_ready), .d_valid(d_valid), .d_opcode(d_opcode), .d_data(d_data), .d_ready(d_ready),
      .gnt(gnt), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (m_dv[1] && m_dr[1]) m1_hs <= m1_hs + 1;

   typedef struct {
      logic       rst_n, av0, av1, ar, dv, dr0, dr1;
      logic [1:0] g;
      logic       sav, sar0, sar1, sdr, sdv0, sdv1, sbusy;
      logic [3:0] addr;
      logic [31:0] dd0, dd1;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m_av = 2'b00; m_dr = 2'b00; a_ready = 1'b0; d_valid = 1'b0; d_opcode = 4'h0; d_data = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_all();
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   function automatic logic [127:0] all_out();
      return {m_ar, m_dv, m_dop, m_dd, a_valid, a_opcode, a_mask, a_address, a_data, d_ready, gnt, busy};
   endfunction

   function automatic logic [31:0] resp_data(input logic [3:0] op, mask, addr, input logic [31:0] d);
      return {d[15:0], d[31:16]} ^ {mask, op, 20'h0, addr} ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [3:0] resp_op(input logic [3:0] op, addr);
      return op ^ addr;
   endfunction

   // transaction-level model state for the random phase
   int          st [2];
   logic [31:0] exp_d [2], got_d [2];
   logic [3:0]  exp_op [2], got_op [2];
   logic [1:0]  hs_a, hs_d, prev_gnt, prev_req;
   logic        hs_sa, hs_sd, prev_dhs, last_m, sl_pend;
   int          sl_dly, n_done;
   logic [3:0]  sa_op, sa_mask, sa_addr, sl_op;
   logic [31:0] sa_data, sl_dat;
   logic [1:0]  exp_g;

   initial begin
      localparam logic [31:0] D = 32'h1234_5678;
      rst_n = 1'b0;
      idle_all();
      m_op[0] = 4'h4; m_addr[0] = 4'h3; m_mask[0] = 4'hF; m_ad[0] = 32'hA5A5_0F0F;
      m_op[1] = 4'h1; m_addr[1] = 4'hC; m_mask[1] = 4'h3; m_ad[1] = 32'h5A5A_F0F0;

      //             rst av0 av1 ar dv dr0 dr1   g   sav sr0 sr1 sdr sdv0 sdv1 bsy addr dd0 dd1
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0};
      tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0};
      tbl[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h3,32'h0,32'h0};
      tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b01,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,4'h0,D,32'h0};
      tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0};
      tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0};
      tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'hC,32'h0,32'h0};
      tbl[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'hC,32'h0,32'h0};
      tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,4'h0,32'h0,D};
      tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,32'h0,D};
      tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 2'b10,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,4'h0,32'h0,D};
      tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,32'h0};

      d_data = D; d_opcode = 4'h1;
      for (int i = 0; i < 12; i++) begin
         rst_n = tbl[i].rst_n; m_av = {tbl[i].av1, tbl[i].av0}; a_ready = tbl[i].ar;
         d_valid = tbl[i].dv; m_dr = {tbl[i].dr1, tbl[i].dr0};
         #2;
         chk($sformatf("table_row%0d", i),
             {gnt, a_valid, m_ar[0], m_ar[1], d_ready, m_dv[0], m_dv[1], busy, a_address, m_dd[0], m_dd[1]},
             {tbl[i].g, tbl[i].sav, tbl[i].sar0, tbl[i].sar1, tbl[i].sdr, tbl[i].sdv0, tbl[i].sdv1,
              tbl[i].sbusy, tbl[i].addr, tbl[i].dd0, tbl[i].dd1});
         cyc();
      end

      // both masters requesting continuously against a zero-wait slave
      do_reset();
      m_av = 2'b11; m_dr = 2'b11; a_ready = 1'b1; d_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #2;
         chk($sformatf("tie_cycle%0d", k), gnt,
             (k % 3 == 0) ? 2'b00 : (FIXED ? 2'b01 : (((k / 3) % 2 == 1) ? 2'b10 : 2'b01)));
         cyc();
      end

      // backpressure on both channels for master 1
      do_reset();
      m_av[1] = 1'b1;
      cyc();
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("bp_a_hold", {gnt, a_valid, a_opcode, a_mask, a_address, a_data, m_ar[1]},
             {2'b10, 1'b1, 4'h1, 4'h3, 4'hC, 32'h5A5A_F0F0, 1'b0});
         cyc();
      end
      a_ready = 1'b1;
      #2 chk("bp_a_accept", m_ar[1], 1'b1);
      cyc();
      m_av[1] = 1'b0; a_ready = 1'b0; d_valid = 1'b1; d_data = 32'hFEED_0001;
      for (int k = 0; k < 3; k++) begin
         #2 chk("bp_d_hold", {m_dv[1], d_ready, m_dd[1]}, {1'b1, 1'b0, 32'hFEED_0001});
         cyc();
      end
      begin
         int hs0;
         hs0 = m1_hs;
         m_dr[1] = 1'b1;
         cyc();
         for (int k = 0; k < 3; k++) begin
            #2 chk("bp_after_stray", {d_ready, m_dv}, 3'b000);
            cyc();
         end
         chk("bp_one_d_handshake", m1_hs - hs0, 1);
      end

      // abandon by master 1 after master 0 was served last
      idle_all();
      m_av[0] = 1'b1; cyc();
      a_ready = 1'b1; cyc();
      m_av[0] = 1'b0; a_ready = 1'b0; d_valid = 1'b1; m_dr[0] = 1'b1; cyc();
      d_valid = 1'b0; m_dr[0] = 1'b0;
      m_av[1] = 1'b1; cyc();
      #2 chk("abandon_grant", gnt, 2'b10);
      m_av[1] = 1'b0;
      #1 chk("abandon_a_zero", {a_valid, a_opcode, a_mask, a_address, a_data}, 45'h0);
      cyc();
      #2 chk("abandon_idle", {busy, gnt}, 3'b000);
      m_av = 2'b11; cyc();
      #2 chk("abandon_tie", gnt, FIXED ? 2'b01 : 2'b10);

      // reset landing in the middle of a response phase
      do_reset();
      m_av[0] = 1'b1; cyc();
      a_ready = 1'b1; cyc();
      m_av[0] = 1'b0; a_ready = 1'b0; d_valid = 1'b1; d_data = 32'h0BAD_CAFE;
      #2 chk("rst_pre_dph", {gnt, m_dv[0]}, 3'b011);
      rst_n = 1'b0;
      #1 chk("rst_all_zero", all_out(), 128'h0);
      cyc();
      rst_n = 1'b1; d_valid = 1'b0; m_av[1] = 1'b1;
      cyc();
      #2 chk("rst_regrant", {gnt, a_valid}, 3'b101);

      // randomized traffic against the transaction model
      do_reset();
      st[0] = 0; st[1] = 0; hs_a = 0; hs_d = 0; hs_sa = 0; hs_sd = 0;
      prev_gnt = 0; prev_req = 0; prev_dhs = 0; last_m = 1'b1; sl_pend = 0; sl_dly = 0; n_done = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (hs_d[n]) chk("unexpected_resp", st[n] != 2, 1'b0);
            if (st[n] == 2 && hs_d[n]) begin
               chk($sformatf("m%0d_response", n), {got_op[n], got_d[n]}, {exp_op[n], exp_d[n]});
               st[n] = 0;
               n_done++;
            end
            if (st[n] == 1 && hs_a[n]) begin
               st[n] = 2;
               m_av[n] = 1'b0;
            end
            if (st[n] == 0 && $urandom_range(0, 2) == 0) begin
               st[n] = 1;
               m_av[n] = 1'b1;
               m_op[n] = 4'($urandom); m_mask[n] = 4'($urandom); m_addr[n] = 4'($urandom);
               m_ad[n] = $urandom;
               exp_d[n] = resp_data(m_op[n], m_mask[n], m_addr[n], m_ad[n]);
               exp_op[n] = resp_op(m_op[n], m_addr[n]);
            end
            m_dr[n] = ($urandom_range(0, 3) != 0);
         end
         if (hs_sa) chk("one_outstanding", sl_pend, 1'b0);
         if (hs_sd) chk("stray_ack", sl_pend, 1'b1);
         if (hs_sd) sl_pend = 1'b0;
         if (hs_sa) begin
            sl_pend = 1'b1;
            sl_dly = $urandom_range(0, 3);
            sl_op = resp_op(sa_op, sa_addr);
            sl_dat = resp_data(sa_op, sa_mask, sa_addr, sa_data);
         end else if (sl_pend && sl_dly > 0) begin
            sl_dly--;
         end
         a_ready = ($urandom_range(0, 2) != 0);
         if (sl_pend) begin
            d_valid = (sl_dly == 0); d_opcode = sl_op; d_data = sl_dat;
         end else begin
            d_valid = ($urandom_range(0, 7) == 0); d_opcode = 4'($urandom); d_data = $urandom;
         end

         #2;
         if (prev_gnt == 2'b00) begin
            exp_g = (prev_req == 2'b11) ? (FIXED ? 2'b01 : (last_m ? 2'b01 : 2'b10)) : prev_req;
            chk("rand_grant", gnt, exp_g);
         end
         if (prev_dhs) chk("rand_gap", gnt, 2'b00);
         chk("rand_gnt_busy", {gnt == 2'b11, busy}, {1'b0, gnt != 2'b00});
         for (int n = 0; n < 2; n++)
            if (!gnt[n]) chk("rand_nonowner", {m_ar[n], m_dv[n], m_dop[n], m_dd[n]}, 38'h0);
         if (!a_valid) chk("rand_a_zero", {a_opcode, a_mask, a_address, a_data}, 44'h0);
         if (!busy) chk("rand_d_ready_idle", d_ready, 1'b0);

         hs_a = m_av & m_ar;
         hs_d = m_dv & m_dr;
         for (int n = 0; n < 2; n++) begin
            got_d[n] = m_dd[n];
            got_op[n] = m_dop[n];
         end
         hs_sa = a_valid && a_ready;
         hs_sd = d_valid && d_ready;
         sa_op = a_opcode; sa_mask = a_mask; sa_addr = a_address; sa_data = a_data;
         if (hs_d[0]) last_m = 1'b0;
         if (hs_d[1]) last_m = 1'b1;
         prev_gnt = gnt;
         prev_req = m_av;
         prev_dhs = |hs_d;
         cyc();
      end
      chk("rand_progress", n_done > 50, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
